p2parn_bank: RTL
================

# p2parn_bank

Parametrised, clocked successor to the two-pull-up / one-pull-down ratioed cell in the rail12lp library. It provides WIDTH independent lanes. Each lane evaluates NP active-low pull-up inputs against NN active-high pull-down inputs. Lane outputs are registered, with a keeper on float and a selectable contention-resolution mode. Per-lane contention flags and a saturating contention-cycle counter are included, for characterisation and silicon-debug wrappers around ratioed-logic arrays.

## Interface
- WIDTH, 4: number of independent lanes.
- NP, 2: pull-up (pfet) inputs per lane. Each input is active-low; must be ≥1.
- NN, 1: pull-down (nfet) inputs per lane. Each input is active-high; must be ≥1.
- MODE, 0: contention resolution. 0 = pull-down wins (ratioed); 1 = keeper holds previous value.
- RESET_VAL, 0: reset value of every Z bit.
- CNT_W, 8: contention counter width, ≥2.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- EN  input  1  evaluate enable. When low, all state holds.
- A  input  WIDTH*NP  pull-up gates; lane i uses A[i*NP +: NP].
- C  input  WIDTH*NN  pull-down gates; lane i uses C[i*NN +: NN].
- CLR  input  1  synchronous clear of CNT and SAT.
- Z  output  WIDTH  registered lane outputs.
- ZX  output  WIDTH  registered per-lane contention flags.
- CNT  output  CNT_W  saturating count of contention cycles.
- SAT  output  1  sticky; set when CNT reaches all-ones.

## Operation
- Per-lane combinational terms:
  - pu[i] = OR over j of !A[i*NP+j].
  - pd[i] = OR over k of C[i*NN+k].
- Next Z[i] when EN=1:
  - pu & !pd → 1.
  - !pu & pd → 0.
  - !pu & !pd → Z[i] (keeper, float hold).
  - pu & pd → 0 if MODE=0; Z[i] if MODE=1.
- Next ZX[i] when EN=1: pu[i] & pd[i]. ZX is a fresh per-cycle flag, not sticky.
- any_x = OR over i of (pu[i] & pd[i]).
- Counter update on each CK edge:
  - CLR=1 → CNT=0, SAT=0. CLR wins over a simultaneous contention event.
  - Else EN=1 & any_x & CNT≠all-ones → CNT+1.
  - Else hold.
- Counter saturates at 2^CNT_W−1 and never wraps.
- SAT is set on the same edge CNT becomes all-ones. It remains set until CLR or RN, even if CNT later holds.
- EN=0: Z, ZX, CNT and SAT all hold. Inputs are ignored, including contention.
- The counter counts cycles, not lanes. Several contending lanes in one cycle add 1.
- X/Z on A or C is not modelled. Inputs are treated as 2-state; the bench drives only 0/1.

## Timing
- Reset: RN low asynchronously forces Z=RESET_VAL (all bits), ZX=0, CNT=0, SAT=0. Reset holds while RN is low.
- Reset release: RN rising takes effect without waiting for CK. The first evaluation is at the first CK rise with RN high.
- Reset mid-operation (RN low between edges) clears immediately, including a saturated counter.
- Latency: inputs sampled at CK edge n appear on Z/ZX at edge n (one register stage). The next evaluation uses the Z value registered at edge n.
- CLR latency: one edge. CNT reads 0 after the edge at which CLR=1 was sampled.
- No combinational path from inputs to outputs.

## Test plan
- Reset: WIDTH=4, RESET_VAL=1. Assert RN=0 mid-cycle with CNT=5 → immediately Z=4'hF, ZX=0, CNT=0, SAT=0, without a clock edge.
- Truth table, lane 0 (NP=2, NN=1, MODE=0), EN=1:
  - A=2'b01, C=0 → Z[0]=1.
  - then A=2'b11, C=1 → Z[0]=0.
  - then A=2'b11, C=0 → Z[0] stays 0 (keeper).
- Contention mode: lane 0 at Z=1, drive A=2'b00, C=1.
  - MODE=0 → Z[0]=0, ZX[0]=1, CNT increments by 1.
  - MODE=1 → Z[0] stays 1, ZX[0]=1.
- Multi-lane: all 4 lanes contend for 3 cycles → CNT=3, not 12. With EN=0 and contention on the inputs, CNT stays 3 and Z is unchanged.
- Saturation: CNT_W=2, 5 contention cycles → CNT=3 with SAT=1 from the 3rd cycle, no wrap. Then CLR=1 together with contention → CNT=0, SAT=0.
- Randomised lanes (1000 cycles, random A/C/EN/CLR, occasional RN pulses) against a reference model → exact match on Z, ZX, CNT and SAT every cycle.

Source files
------------

// File: rtl/p2parn_bank.sv
// Bank of WIDTH clocked ratioed cells: NP active-low pull-ups against NN active-high
// pull-downs per lane, with a keeper on float, contention flags and a saturating counter.
module p2parn_bank #(
    parameter int WIDTH     = 4,
    parameter int NP        = 2,
    parameter int NN        = 1,
    parameter int MODE      = 0,
    parameter int RESET_VAL = 0,
    parameter int CNT_W     = 8
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  EN,
    input  logic [WIDTH*NP-1:0]   A,
    input  logic [WIDTH*NN-1:0]   C,
    input  logic                  CLR,
    output logic [WIDTH-1:0]      Z,
    output logic [WIDTH-1:0]      ZX,
    output logic [CNT_W-1:0]      CNT,
    output logic                  SAT
);

    localparam logic RV = (RESET_VAL != 0);

    logic [WIDTH-1:0] pu_p0;
    logic [WIDTH-1:0] pd_p0;
    logic [WIDTH-1:0] xs_p0;
    logic [WIDTH-1:0] z_nxt_p0;
    logic             any_x_p0;
    logic [CNT_W-1:0] cnt_nxt_p0;

    logic [WIDTH-1:0] z_p1;
    logic [WIDTH-1:0] zx_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             sat_p1;

    // Resolves one lane; a fighting lane follows the pull-down unless MODE selects the keeper.
    function automatic logic lane_next(input logic pu, input logic pd, input logic zq);
        logic r;
        if (pu && !pd)
            r = 1'b1;
        else if (!pu && pd)
            r = 1'b0;
        else if (!pu && !pd)
            r = zq;
        else
            r = (MODE == 0) ? 1'b0 : zq;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v)
            r = v;
        else
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    // Stage p0: combinational lane evaluation against the registered outputs
    always_comb begin
        pu_p0    = '0;
        pd_p0    = '0;
        z_nxt_p0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pu_p0[i]    = ~&A[i*NP +: NP];
            pd_p0[i]    = |C[i*NN +: NN];
            z_nxt_p0[i] = lane_next(pu_p0[i], pd_p0[i], z_p1[i]);
        end
    end

    assign xs_p0      = pu_p0 & pd_p0;
    assign any_x_p0   = |xs_p0;
    assign cnt_nxt_p0 = sat_inc(cnt_p1);

    // Stage p1: registered lane outputs, flags and contention counter
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            z_p1   <= {WIDTH{RV}};
            zx_p1  <= '0;
            cnt_p1 <= '0;
            sat_p1 <= 1'b0;
        end else begin
            if (EN) begin
                z_p1  <= z_nxt_p0;
                zx_p1 <= xs_p0;
            end
            if (CLR) begin
                cnt_p1 <= '0;
                sat_p1 <= 1'b0;
            end else if (EN && any_x_p0 && !(&cnt_p1)) begin
                cnt_p1 <= cnt_nxt_p0;
                if (&cnt_nxt_p0)
                    sat_p1 <= 1'b1;
            end
        end
    end

    assign Z   = z_p1;
    assign ZX  = zx_p1;
    assign CNT = cnt_p1;
    assign SAT = sat_p1;

endmodule
